// File: rtl/plc_mirror_writer.sv
// plc_mirror_writer: captures protected cache writes into a small FIFO and
// replays each one as a mirror write (address XOR MIRROR_XOR, same way) during
// idle cache cycles, then pulses the {original, mirror} tuple to the PLC list.
// Optional build macro: PLC_MIRROR_STALL_EN -- when defined, stall = FIFO full
// so the store pipeline holds protected writes instead of having them dropped.
module plc_mirror_writer #(
   parameter int                    ADDR_WIDTH      = 8,
   parameter int                    WAY_WIDTH       = 4,
   parameter int                    DATA_SIZE       = 64,
   parameter int                    FIFO_DEPTH      = 4,
   parameter int                    FIFO_DEPTH_BITS = 2,
   parameter logic [ADDR_WIDTH-1:0] MIRROR_XOR      = 'h80
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    add_to_list,
   input  logic                    write_enable_in,
   input  logic                    read_enable_in,
   input  logic [ADDR_WIDTH-1:0]   addr_in,
   input  logic [WAY_WIDTH-1:0]    way_in,
   input  logic [DATA_SIZE-1:0]    wdata_in,
   output logic                    write_enable_out,
   output logic [ADDR_WIDTH-1:0]   addr_out,
   output logic [WAY_WIDTH-1:0]    way_out,
   output logic [DATA_SIZE-1:0]    wdata_out,
   output logic [2*ADDR_WIDTH-1:0] add_addr_tuple,
   output logic [2*WAY_WIDTH-1:0]  add_way_tuple,
   output logic                    add_flag,
   output logic                    stall,
   output logic                    overflow_error
);

   typedef enum logic [1:0] {IDLE, PEND, NOTIFY} state_t;

   localparam logic [FIFO_DEPTH_BITS:0]   DEPTH_C = FIFO_DEPTH[FIFO_DEPTH_BITS:0];
   localparam logic [FIFO_DEPTH_BITS:0]   CNT_ONE = 1;
   localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ONE = 1;

   state_t                     state_q, state_d;
   logic [FIFO_DEPTH_BITS:0]   count_q;
   logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
   logic [2*ADDR_WIDTH-1:0]    tuple_addr_q;
   logic [2*WAY_WIDTH-1:0]     tuple_way_q;
   logic                       overflow_q;

   logic [ADDR_WIDTH-1:0]      fifo_addr_q [FIFO_DEPTH];
   logic [WAY_WIDTH-1:0]       fifo_way_q  [FIFO_DEPTH];
   logic [DATA_SIZE-1:0]       fifo_data_q [FIFO_DEPTH];

   logic                       access, idle, full, push, drop, issue;
   logic [ADDR_WIDTH-1:0]      head_addr, head_mirror;
   logic [WAY_WIDTH-1:0]       head_way;
   logic [DATA_SIZE-1:0]       head_data;

   assign access      = read_enable_in | write_enable_in;
   assign idle        = ~access;
   assign full        = (count_q == DEPTH_C);
   // Push and pop are mutually exclusive: pop needs an idle cycle, push a write.
   assign push        = write_enable_in & add_to_list & ~full & ~rst;
   assign drop        = write_enable_in & add_to_list & full;
   assign head_addr   = fifo_addr_q[rd_ptr_q];
   assign head_way    = fifo_way_q[rd_ptr_q];
   assign head_data   = fifo_data_q[rd_ptr_q];
   assign head_mirror = head_addr ^ MIRROR_XOR;

   // Next-state logic; issue and add_flag are suppressed while rst is high so
   // nothing leaks out of a state that reset is about to clear.
   always_comb begin
      state_d  = state_q;
      issue    = 1'b0;
      add_flag = 1'b0;
      case (state_q)
         IDLE: begin
            if (push) state_d = PEND;
         end
         PEND: begin
            if (idle) begin
               issue   = 1'b1;
               state_d = NOTIFY;
            end
         end
         NOTIFY: begin
            add_flag = 1'b1;
            if ((count_q != '0) || push) state_d = PEND;
            else                         state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (rst) begin
         issue    = 1'b0;
         add_flag = 1'b0;
      end
   end

   // Cache write port: mirror write when issuing, otherwise straight pass-through.
   always_comb begin
      write_enable_out = write_enable_in;
      addr_out         = addr_in;
      way_out          = way_in;
      wdata_out        = wdata_in;
      if (issue) begin
         write_enable_out = 1'b1;
         addr_out         = head_mirror;
         way_out          = head_way;
         wdata_out        = head_data;
      end
   end

   assign add_addr_tuple = tuple_addr_q;
   assign add_way_tuple  = tuple_way_q;
   assign overflow_error = overflow_q;

`ifdef PLC_MIRROR_STALL_EN
   assign stall = full & ~rst;
`else
   assign stall = 1'b0;
`endif

   // Control state: FSM, occupancy, pointers, latched tuple, sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         count_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         tuple_addr_q <= '0;
         tuple_way_q  <= '0;
         overflow_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
            count_q  <= count_q + CNT_ONE;
         end
         if (issue) begin
            rd_ptr_q     <= rd_ptr_q + PTR_ONE;
            count_q      <= count_q - CNT_ONE;
            tuple_addr_q <= {head_addr, head_mirror};
            tuple_way_q  <= {head_way, head_way};
         end
         if (drop) overflow_q <= 1'b1;
      end
   end

   // FIFO payload storage; contents are only meaningful below count_q.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= addr_in;
         fifo_way_q[wr_ptr_q]  <= way_in;
         fifo_data_q[wr_ptr_q] <= wdata_in;
      end
   end

endmodule

// File: tb/tb_plc_mirror_writer.sv
// Directed bench for plc_mirror_writer with a scoreboard of expected mirror
// writes and PLC tuples. Honours PLC_MIRROR_STALL_EN for the overflow/stall case.
module tb_plc_mirror_writer;

`ifdef PLC_MIRROR_STALL_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif

   logic        clk, rst, add_to_list, write_enable_in, read_enable_in;
   logic [7:0]  addr_in;
   logic [3:0]  way_in;
   logic [63:0] wdata_in;
   logic        write_enable_out;
   logic [7:0]  addr_out;
   logic [3:0]  way_out;
   logic [63:0] wdata_out;
   logic [15:0] add_addr_tuple;
   logic [7:0]  add_way_tuple;
   logic        add_flag, stall, overflow_error;

   plc_mirror_writer dut (
      .clk(clk), .rst(rst), .add_to_list(add_to_list),
      .write_enable_in(write_enable_in), .read_enable_in(read_enable_in),
      .addr_in(addr_in), .way_in(way_in), .wdata_in(wdata_in),
      .write_enable_out(write_enable_out), .addr_out(addr_out),
      .way_out(way_out), .wdata_out(wdata_out),
      .add_addr_tuple(add_addr_tuple), .add_way_tuple(add_way_tuple),
      .add_flag(add_flag), .stall(stall), .overflow_error(overflow_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {logic [7:0] a; logic [3:0] w; logic [63:0] d;} mir_t;
   typedef struct packed {logic [15:0] a; logic [7:0] w;} tup_t;

   mir_t mq[$];
   tup_t tq[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive after posedge, check on the following negedge.
   task automatic step(input logic r, input logic we, input logic re, input logic atl,
                       input logic [7:0] a, input logic [3:0] w, input logic [63:0] d,
                       input logic enq, input logic exp_mir, input logic exp_flag,
                       input logic exp_stall);
      mir_t m;
      tup_t t;
      @(posedge clk);
      #1;
      rst = r; write_enable_in = we; read_enable_in = re; add_to_list = atl;
      addr_in = a; way_in = w; wdata_in = d;
      if (enq) mq.push_back('{a ^ 8'h80, w, d});
      @(negedge clk);
      if (exp_mir) begin
         chk("mirror_we", 64'(write_enable_out), 64'(1'b1));
         if (mq.size() == 0) begin
            n_vec++; n_miss++;
            $error("FAIL mirror_queue observed=empty expected=entry");
         end else begin
            m = mq.pop_front();
            chk("mirror_addr", 64'(addr_out), 64'(m.a));
            chk("mirror_way", 64'(way_out), 64'(m.w));
            chk("mirror_data", wdata_out, m.d);
            tq.push_back('{{m.a ^ 8'h80, m.a}, {m.w, m.w}});
         end
      end else begin
         chk("pass_we", 64'(write_enable_out), 64'(we));
         chk("pass_addr", 64'(addr_out), 64'(a));
         chk("pass_way", 64'(way_out), 64'(w));
         chk("pass_data", wdata_out, d);
      end
      chk("add_flag", 64'(add_flag), 64'(exp_flag));
      if (exp_flag) begin
         if (tq.size() == 0) begin
            n_vec++; n_miss++;
            $error("FAIL tuple_queue observed=empty expected=entry");
         end else begin
            t = tq.pop_front();
            chk("tuple_addr", 64'(add_addr_tuple), 64'(t.a));
            chk("tuple_way", 64'(add_way_tuple), 64'(t.w));
         end
      end
      chk("stall", 64'(stall), 64'(exp_stall));
   endtask

   task automatic idle_step(input logic exp_mir, input logic exp_flag, input logic exp_stall);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 64'h0, 1'b0, exp_mir, exp_flag, exp_stall);
   endtask

   task automatic pwrite(input logic [7:0] a, input logic [3:0] w, input logic [63:0] d,
                         input logic enq);
      step(1'b0, 1'b1, 1'b0, 1'b1, a, w, d, enq, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; write_enable_in = 1'b0; read_enable_in = 1'b0; add_to_list = 1'b0;
      addr_in = '0; way_in = '0; wdata_in = '0;
      repeat (2) @(posedge clk);

      // Reset values and pass-through while held in reset
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h33, 4'h7, 64'h1122_3344_5566_7788, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_overflow", 64'(overflow_error), 64'(1'b0));
      chk("rst_tuple_addr", 64'(add_addr_tuple), 64'h0);
      chk("rst_tuple_way", 64'(add_way_tuple), 64'h0);

      // Basic mirror: write at N, mirror at N+1, tuple at N+2
      pwrite(8'h12, 4'b0010, 64'hA5A5_0000_0000_5A5A, 1'b1);
      idle_step(1'b1, 1'b0, 1'b0);
      chk("t1_mirror_addr", 64'(addr_out), 64'h92);
      idle_step(1'b0, 1'b1, 1'b0);
      chk("t1_tuple_addr", 64'(add_addr_tuple), 64'h1292);
      chk("t1_tuple_way", 64'(add_way_tuple), 64'h22);
      idle_step(1'b0, 1'b0, 1'b0);

      // Mirror deferred by 5 busy read cycles
      pwrite(8'h40, 4'h5, 64'hDEAD_BEEF_0123_4567, 1'b1);
      for (int i = 0; i < 5; i++)
         step(1'b0, 1'b0, 1'b1, 1'b0, 8'h41 + 8'(i), 4'h3, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle_step(1'b1, 1'b0, 1'b0);
      idle_step(1'b0, 1'b1, 1'b0);

      // Unprotected write is ignored
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 4'h1, 64'hCAFE, 1'b0, 1'b0, 1'b0, 1'b0);
      idle_step(1'b0, 1'b0, 1'b0);
      idle_step(1'b0, 1'b0, 1'b0);

      // Fill the FIFO; fifth write dropped unless stall is built in
      for (int i = 1; i <= 4; i++)
         pwrite(8'(i), 4'(i), 64'h1000 + 64'(i), 1'b1);
      if (!STALL_EN)
         pwrite(8'h05, 4'h5, 64'h1005, 1'b0);
      for (int i = 0; i < 4; i++) begin
         idle_step(1'b1, 1'b0, STALL_EN && (i == 0));
         idle_step(1'b0, 1'b1, 1'b0);
      end
      chk("overflow_sticky", 64'(overflow_error), 64'(!STALL_EN));
      idle_step(1'b0, 1'b0, 1'b0);

      // Reset during NOTIFY with one entry still queued
      pwrite(8'h20, 4'h6, 64'h2020, 1'b1);
      pwrite(8'h21, 4'h6, 64'h2121, 1'b1);
      idle_step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      mq.delete();
      tq.delete();
      idle_step(1'b0, 1'b0, 1'b0);
      chk("post_rst_overflow", 64'(overflow_error), 64'(1'b0));
      chk("post_rst_tuple", 64'(add_addr_tuple), 64'h0);
      idle_step(1'b0, 1'b0, 1'b0);
      idle_step(1'b0, 1'b0, 1'b0);
      pwrite(8'h33, 4'h9, 64'h3333_0000_3333_0000, 1'b1);
      idle_step(1'b1, 1'b0, 1'b0);
      idle_step(1'b0, 1'b1, 1'b0);
      idle_step(1'b0, 1'b0, 1'b0);

      chk("mirror_queue_drained", 64'(mq.size()), 64'h0);
      chk("tuple_queue_drained", 64'(tq.size()), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
